i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S serial audio receiver feeding the high-pass `top_filter` cascade. It oversamples the external I2S bit clock, word select and data lines in the system `clk` domain, then deserialises one k-bit two's-complement word per channel. Once per stereo frame it presents parallel left and right samples together with a single-cycle `sample_trig` strobe, which drives the first `sos` stage directly.

## Interface
- `k`, 24: captured sample width in bits, MSB first; must be ≤ `n`.
- `n`, 32: I2S slot width in bit clocks per channel; bits beyond the first `k` are discarded.
- `clk`  in  1: system clock; must run at ≥ 4× the `i2s_bclk` frequency.
- `reset`  in  1: synchronous, active-high; clears all state on the next `clk` rising edge.
- `i2s_bclk`  in  1: I2S bit clock, asynchronous to `clk`.
- `i2s_lrclk`  in  1: word select, asynchronous; 0 = left, 1 = right.
- `i2s_sdata`  in  1: serial data, asynchronous; valid on `i2s_bclk` rising edges.
- `audio_l`  out  k: last complete left sample.
- `audio_r`  out  k: last complete right sample; connects to `top_filter.audio_in`.
- `sample_trig`  out  1: one-cycle pulse when a new left/right pair is valid.
- `frame_err`  out  1: one-cycle pulse when a channel word is truncated.

## Operation
- **Synchronisers:** two flip-flops on each of `i2s_bclk`, `i2s_lrclk`, `i2s_sdata`, then one history register on bclk and lrclk.
  - `bclk_rise` = synced bclk high AND history low.
  - `lr_edge` is evaluated only in a `bclk_rise` cycle: synced lrclk ≠ lrclk value latched at the previous `bclk_rise`.
- **State machine** (all transitions occur in `bclk_rise` cycles):
  - IDLE: wait for an lrclk falling edge (start of left slot) → DELAY. Until the first falling edge, no output is produced after reset.
  - DELAY: skip the one-bit I2S delay → SHIFT. Clears the bit counter; records the channel from the current lrclk value.
  - SHIFT: shift `sdata` into a k-bit register MSB-first and increment the counter.
    - When counter reaches k: load the shift register into the channel's holding register → WAIT.
    - A right-channel completion also asserts `sample_trig`, provided the left word of the same frame also completed.
  - WAIT: ignore bits until `lr_edge` → DELAY.
- **Truncated word:** `lr_edge` while in SHIFT with counter < k.
  - Discard the partial word and pulse `frame_err`.
  - Clear the left-valid flag, so no `sample_trig` is issued for that frame.
  - Go to DELAY for the new channel.
- **Pairing:** left-complete sets a `left_ok` flag. The right-complete cycle loads `audio_r`, transfers the pending left word to `audio_l`, pulses `sample_trig` only if `left_ok` is set, then clears `left_ok`.
- **Output stability:** `audio_l` and `audio_r` change only in `sample_trig` cycles and are stable until the next one.
- **Width rules:**
  - Bit counter is $clog2(n+1) bits; it saturates at n in WAIT.
  - Data is passed unchanged as two's complement; no rounding or sign extension.
- **Reset:** from any state, including mid-word, returns to IDLE. All outputs, flags, counters and synchroniser registers are cleared to 0.

## Timing
- Input to internal edge: 3 `clk` cycles from an input transition to the `bclk_rise` cycle (2 sync + 1 history).
- `sample_trig` latency: registered; asserted 1 `clk` after the `bclk_rise` that samples the k-th right-channel bit. `audio_l`/`audio_r` are updated in that same cycle.
- Pulse widths: `sample_trig` and `frame_err` are exactly one `clk` cycle wide.
  - At most one `sample_trig` per lrclk period.
  - `frame_err` never coincides with `sample_trig`.
- Simultaneous events: if the k-th bit and `lr_edge` occur in the same `bclk_rise` (exactly k bits, k = n), the word is complete. It is latched, no error is raised, and the FSM goes to DELAY.
- Throughput: one stereo pair per 2·n bclk periods.

## Test plan
- **Nominal frame:** reset, then at `clk` = 8× bclk send left 0x123456, right 0xABCDEF with n = 32 (zero pad) → one `sample_trig`; `audio_l` = 0x123456, `audio_r` = 0xABCDEF; `frame_err` = 0.
- **Reset start-up:** first lrclk edge after reset is rising (right slot first) → right word ignored; first `sample_trig` only after a full left+right frame; outputs read 0 until then.
- **Truncated slot:** left slot only 16 bclk long with k = 24 → `frame_err` pulse 1 cycle; no `sample_trig` that frame; the next clean frame 0x7FFFFF/0x800000 gives `sample_trig` with those values.
- **Slot equals k:** set n = k = 24 and send 0x000001/0xFFFFFF back-to-back with `lr_edge` on the 24th bit → `sample_trig` with correct values; no error.
- **Mid-word reset:** assert `reset` for 1 cycle halfway through a right word → all outputs 0 next cycle; no `sample_trig`; the following full frame is decoded correctly.
- **Throughput:** 100 consecutive frames of random data → exactly 100 `sample_trig` pulses; each pair matches the transmitted data; `audio_l`/`audio_r` change only on `sample_trig`.

Source files
------------

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S serial audio receiver: oversampled, deserialised stereo pairs with a frame strobe
module i2s_rx #(
    parameter int k = 24,
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i2s_bclk,
    input  logic         i2s_lrclk,
    input  logic         i2s_sdata,
    output logic [k-1:0] audio_l,
    output logic [k-1:0] audio_r,
    output logic         sample_trig,
    output logic         frame_err
);

    localparam int cw = $clog2(n + 1);
    localparam logic [cw-1:0] k_cnt = cw'(k);
    localparam logic [cw-1:0] n_cnt = cw'(n);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        WAIT
    } state_t;

    // two-stage synchronisers plus a bclk history bit
    logic bclk_s1, bclk_s2, bclk_h;
    logic lr_s1, lr_s2;
    logic sd_s1, sd_s2;

    // lrclk as seen at the previous bclk rising edge
    logic lr_prev;

    state_t        state;
    logic [cw-1:0] cnt;
    logic [k-2:0]  shreg;
    logic [k-1:0]  left_hold;
    logic          left_ok;
    logic          chan;

    logic          bclk_rise;
    logic          lr_edge;
    logic [k-1:0]  sh_next;
    logic [cw-1:0] cnt_next;

    // bring the asynchronous I2S lines into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_h  <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_h  <= bclk_s2;
            lr_s1   <= i2s_lrclk;
            lr_s2   <= lr_s1;
            sd_s1   <= i2s_sdata;
            sd_s2   <= sd_s1;
        end
    end

    // edge qualifiers and the next shift/count values for the current bit
    always_comb begin
        bclk_rise = bclk_s2 & ~bclk_h;
        lr_edge   = bclk_rise & (lr_s2 != lr_prev);
        sh_next   = {shreg, sd_s2};
        cnt_next  = cnt + 1'b1;
    end

    // word framing FSM; all state moves happen on a bclk rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            left_ok     <= 1'b0;
            chan        <= 1'b0;
            lr_prev     <= 1'b0;
            audio_l     <= '0;
            audio_r     <= '0;
            sample_trig <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sample_trig <= 1'b0;
            frame_err   <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lr_s2;
                case (state)
                    // only a falling lrclk (left slot start) can begin decoding
                    IDLE: begin
                        if (lr_edge && !lr_s2) begin
                            state <= DELAY;
                            cnt   <= '0;
                            chan  <= 1'b0;
                        end
                    end
                    // the bit under the lrclk edge was the delay slot; DELAY
                    // takes the MSB on the next rise, SHIFT the remaining bits
                    DELAY, SHIFT: begin
                        shreg <= sh_next[k-2:0];
                        cnt   <= cnt_next;
                        if (cnt_next == k_cnt) begin
                            if (!chan) begin
                                left_hold <= sh_next;
                                left_ok   <= 1'b1;
                            end else begin
                                // outputs move only together with the strobe
                                if (left_ok) begin
                                    audio_r     <= sh_next;
                                    audio_l     <= left_hold;
                                    sample_trig <= 1'b1;
                                end
                                left_ok <= 1'b0;
                            end
                            // last bit landing on the lrclk edge still completes
                            if (lr_edge) begin
                                state <= DELAY;
                                cnt   <= '0;
                                chan  <= lr_s2;
                            end else begin
                                state <= WAIT;
                            end
                        end else if (lr_edge) begin
                            // slot ended early: drop the partial word and the frame
                            frame_err <= 1'b1;
                            left_ok   <= 1'b0;
                            state     <= DELAY;
                            cnt       <= '0;
                            chan      <= lr_s2;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                    // padding bits beyond k are ignored until the next channel
                    WAIT: begin
                        if (lr_edge) begin
                            state <= DELAY;
                            cnt   <= '0;
                            chan  <= lr_s2;
                        end else if (cnt < n_cnt) begin
                            cnt <= cnt_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for i2s_rx with n=32 and n=k=24 instances on shared lines
module tb_i2s_rx;

    localparam int k = 24;

    typedef struct packed {
        logic [k-1:0] l;
        logic [k-1:0] r;
    } pair_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bclk = 1'b0;
    logic lr = 1'b0;
    logic sd = 1'b0;
    logic carry = 1'b0;

    logic [k-1:0] al [2];
    logic [k-1:0] ar [2];
    logic         st [2];
    logic         fe [2];

    int n_cmp = 0;
    int n_err = 0;

    pair_t exp_list [$];
    int    idx      [2];
    int    trig_cnt [2];
    int    ferr_cnt [2];
    logic [k-1:0] pl [2];
    logic [k-1:0] pr [2];
    logic         pst [2];
    logic         pfe [2];

    always #5 clk = ~clk;

    i2s_rx #(.k(k), .n(32)) dut_a (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lr), .i2s_sdata(sd),
        .audio_l(al[0]), .audio_r(ar[0]), .sample_trig(st[0]), .frame_err(fe[0])
    );

    i2s_rx #(.k(k), .n(24)) dut_b (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lr), .i2s_sdata(sd),
        .audio_l(al[1]), .audio_r(ar[1]), .sample_trig(st[1]), .frame_err(fe[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_audio_l"}, 32'(al[d]), 32'd0);
            check({tag, "_audio_r"}, 32'(ar[d]), 32'd0);
            check({tag, "_trig"}, 32'(st[d]), 32'd0);
            check({tag, "_ferr"}, 32'(fe[d]), 32'd0);
        end
    endtask

    // one bclk period at clk = 8x bclk; lr/data change with bclk falling
    task automatic bit_period(input logic lrv, input logic dv, input bit do_rst);
        bclk = 1'b0;
        lr   = lrv;
        sd   = dv;
        if (do_rst) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_zero_outputs("midword_reset");
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // first period carries the previous slot's last bit (I2S one-bit delay)
    task automatic send_slot(input logic lrv, input logic [k-1:0] w, input int len, input int rst_at);
        logic b;
        bit_period(lrv, carry, rst_at == 0);
        for (int i = 0; i < len - 1; i++) begin
            b = (i < k) ? w[k-1-i] : 1'b0;
            bit_period(lrv, b, rst_at == i + 1);
        end
        carry = (len - 1 < k) ? w[k-len] : 1'b0;
    endtask

    task automatic frame(input logic [k-1:0] l, input logic [k-1:0] r, input int len);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_list.push_back(p);
        send_slot(1'b0, l, len, -1);
        send_slot(1'b1, r, len, -1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            idx[d] = 0;
            trig_cnt[d] = 0;
            ferr_cnt[d] = 0;
            pl[d] = '0;
            pr[d] = '0;
            pst[d] = 1'b0;
            pfe[d] = 1'b0;
        end
    end

    // scoreboard monitor, sampled 3 ns after each rising clk edge
    always @(posedge clk) begin
        #3;
        for (int d = 0; d < 2; d++) begin
            if (st[d]) begin
                trig_cnt[d]++;
                check("trig_has_pending_pair", 32'(exp_list.size() > idx[d]), 32'd1);
                if (exp_list.size() > idx[d]) begin
                    check("audio_l", 32'(al[d]), 32'(exp_list[idx[d]].l));
                    check("audio_r", 32'(ar[d]), 32'(exp_list[idx[d]].r));
                    idx[d]++;
                end
                check("trig_with_ferr", 32'(fe[d]), 32'd0);
                check("trig_width", 32'(pst[d]), 32'd0);
            end
            if (fe[d]) begin
                ferr_cnt[d]++;
                check("ferr_width", 32'(pfe[d]), 32'd0);
            end
            if (!reset && !st[d]) begin
                check("hold_audio_l", 32'(al[d]), 32'(pl[d]));
                check("hold_audio_r", 32'(ar[d]), 32'(pr[d]));
            end
            pl[d]  = al[d];
            pr[d]  = ar[d];
            pst[d] = st[d];
            pfe[d] = fe[d];
        end
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // right slot first after reset is ignored
        send_slot(1'b1, 24'h555555, 32, -1);
        check_zero_outputs("startup");
        for (int d = 0; d < 2; d++) check("startup_trig_cnt", 32'(trig_cnt[d]), 32'd0);

        // nominal frame
        frame(24'h123456, 24'hABCDEF, 32);
        for (int d = 0; d < 2; d++) begin
            check("nominal_trig_cnt", 32'(trig_cnt[d]), 32'd1);
            check("nominal_ferr_cnt", 32'(ferr_cnt[d]), 32'd0);
            check("nominal_audio_l", 32'(al[d]), 32'h123456);
            check("nominal_audio_r", 32'(ar[d]), 32'hABCDEF);
        end

        // truncated 16-bit left slot, then a clean frame
        send_slot(1'b0, 24'h3C3C3C, 16, -1);
        send_slot(1'b1, 24'h0F0F0F, 32, -1);
        for (int d = 0; d < 2; d++) begin
            check("trunc_ferr_cnt", 32'(ferr_cnt[d]), 32'd1);
            check("trunc_trig_cnt", 32'(trig_cnt[d]), 32'd1);
        end
        frame(24'h7FFFFF, 24'h800000, 32);
        for (int d = 0; d < 2; d++) check("after_trunc_trig_cnt", 32'(trig_cnt[d]), 32'd2);

        // slots exactly k long: last bit coincides with the lrclk edge
        frame(24'h000001, 24'hFFFFFF, 24);
        frame(24'h5A5A5A, 24'hA5A5A5, 24);
        for (int d = 0; d < 2; d++) begin
            check("slot_eq_k_trig_cnt", 32'(trig_cnt[d]), 32'd3);
            check("slot_eq_k_ferr_cnt", 32'(ferr_cnt[d]), 32'd1);
        end

        // left completes, reset halfway through the right word
        send_slot(1'b0, 24'h111111, 32, -1);
        send_slot(1'b1, 24'h222222, 32, 12);
        for (int d = 0; d < 2; d++) check("midword_trig_cnt", 32'(trig_cnt[d]), 32'd4);
        frame(24'h246801, 24'h13579B, 32);
        for (int d = 0; d < 2; d++) begin
            check("post_reset_trig_cnt", 32'(trig_cnt[d]), 32'd5);
            check("post_reset_audio_l", 32'(al[d]), 32'h246801);
            check("post_reset_audio_r", 32'(ar[d]), 32'h13579B);
        end

        // throughput with random data
        for (int f = 0; f < 100; f++) begin
            frame(k'($urandom), k'($urandom), 32);
        end
        repeat (40) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check("final_trig_cnt", 32'(trig_cnt[d]), 32'd105);
            check("final_pairs_consumed", 32'(idx[d]), 32'(exp_list.size()));
            check("final_ferr_cnt", 32'(ferr_cnt[d]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
